// File: rtl/mem_bridge_if.sv
// rtl/mem_bridge_if.sv - byte-wide SRAM req/ack port shared by mem_bridge and its memory.
interface mem_bridge_if;
    logic        sram_req;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic        sram_ack;

    modport master (
        output sram_req, sram_we, sram_addr, sram_wdata,
        input  sram_rdata, sram_ack
    );

    modport slave (
        input  sram_req, sram_we, sram_addr, sram_wdata,
        output sram_rdata, sram_ack
    );
endinterface

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - SAP-2 memory stage: MAR/MDR/SP plus req/ack SRAM sequencer.
// Optional MEM_TIMEOUT_EN: abort accesses not acked within TIMEOUT cycles and raise err.
module mem_bridge #(
    parameter logic [15:0] SP_RESET = 16'hFFFF,
    parameter int          TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strobe,
    input  logic [7:0]         bus,
    input  logic [7:0]         ctrl,
    output logic [7:0]         mem_out,
    output logic               busy,
    output logic               err,
    mem_bridge_if.master       sram
);

    typedef enum logic [2:0] {IDLE, RD, WR, PUSH_H, PUSH_L, POP_L, POP_H} state_t;

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d, sp_q, sp_d, addr_q, addr_d;
    logic [7:0]  mdr_q, mdr_d, wdata_q, wdata_d;
    logic        busy_q, busy_d, req_q, req_d, we_q, we_d;
    logic        done, tmo;
    logic [7:0]  rd_byte;
    logic [15:0] mar_fwd;
    logic [7:0]  mdr_fwd;

    wire mar_loadh = ctrl[7];
    wire mar_loadl = ctrl[6];
    wire mdr_load  = ctrl[5];
    wire ram_load  = ctrl[4];
    wire ram_enh   = ctrl[3];
    wire ram_enl   = ctrl[2];
    wire op_call   = ctrl[1];
    wire op_ret    = ctrl[0];

    // Same-strobe register loads are visible to the memory op started by that strobe.
    assign mar_fwd = {mar_loadh ? bus : mar_q[15:8], mar_loadl ? bus : mar_q[7:0]};
    assign mdr_fwd = mdr_load ? bus : mdr_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign tmo     = req_q && !sram.sram_ack && (cnt_q == CW'(TIMEOUT - 1));
    assign rd_byte = tmo ? 8'hFF : sram.sram_rdata;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (req_q && !done) ? cnt_q + 1'b1 : '0;
            if (tmo)
                err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo     = 1'b0;
    assign rd_byte = sram.sram_rdata;
    assign err     = 1'b0;
`endif

    // An ack is only meaningful while a request is actually outstanding.
    assign done = req_q && (sram.sram_ack || tmo);

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        sp_d    = sp_q;
        busy_d  = busy_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                // busy still high in IDLE is the trailing cycle after the last ack.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (strobe) begin
                    mar_d = mar_fwd;
                    mdr_d = mdr_fwd;
                    if (op_call) begin
                        state_d = PUSH_H;
                        busy_d  = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = sp_q;
                        wdata_d = mar_fwd[15:8];
                    end else if (op_ret) begin
                        state_d = POP_L;
                        busy_d  = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = sp_q + 16'd1;
                    end else if (ram_load) begin
                        state_d = WR;
                        busy_d  = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = mar_fwd;
                        wdata_d = mdr_fwd;
                    end else if (ram_enh || ram_enl) begin
                        state_d = RD;
                        busy_d  = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = ram_enh ? mar_fwd + 16'd1 : mar_fwd;
                    end
                end
            end
            default: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (done) begin
                    req_d = 1'b0;
                    case (state_q)
                        RD: begin
                            mdr_d   = rd_byte;
                            state_d = IDLE;
                        end
                        PUSH_H: begin
                            sp_d    = sp_q - 16'd1;
                            addr_d  = sp_q - 16'd1;
                            wdata_d = mar_q[7:0];
                            state_d = PUSH_L;
                        end
                        PUSH_L: begin
                            sp_d    = sp_q - 16'd1;
                            state_d = IDLE;
                        end
                        POP_L: begin
                            mar_d[7:0] = rd_byte;
                            sp_d       = sp_q + 16'd1;
                            addr_d     = sp_q + 16'd2;
                            state_d    = POP_H;
                        end
                        POP_H: begin
                            mar_d[15:8] = rd_byte;
                            sp_d        = sp_q + 16'd1;
                            state_d     = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mar_q   <= 16'h0000;
            mdr_q   <= 8'h00;
            sp_q    <= SP_RESET;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            sp_q    <= sp_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_out         = mdr_q;
    assign busy            = busy_q;
    assign sram.sram_req   = req_q;
    assign sram.sram_we    = we_q;
    assign sram.sram_addr  = addr_q;
    assign sram.sram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - randomized bench for mem_bridge against a sequential memory model.
module tb_mem_bridge;
    localparam int TMO = 16;
    localparam logic [7:0] C_LOADH = 8'h80, C_LOADL = 8'h40, C_MDR = 8'h20, C_WR = 8'h10;
    localparam logic [7:0] C_ENH = 8'h08, C_ENL = 8'h04, C_CALL = 8'h02, C_RET = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] bus = 8'h00;
    logic [7:0] ctrl = 8'h00;
    logic [7:0] mem_out;
    logic       busy, err;

    mem_bridge_if sif();

    mem_bridge #(.SP_RESET(16'hFFFF), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst_n), .strobe(strobe), .bus(bus), .ctrl(ctrl),
        .mem_out(mem_out), .busy(busy), .err(err), .sram(sif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        acc_log[$];
    logic [7:0]  sram_mem [65536];
    logic [7:0]  ref_mem  [65536];
    int          ack_delay = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] m_mar = 16'h0000, m_sp = 16'hFFFF;
    logic [7:0]  m_mdr = 8'h00;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [15:0] a);
        return (ack_delay >= TMO) ? 8'hFF : ref_mem[a];
    endfunction

    task automatic push(input logic [15:0] a, input logic we, input logic [7:0] d);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = d;
        exp_q.push_back(e);
        if (we && ack_delay < TMO) ref_mem[a] = d;
    endtask

    // Architectural effect of one accepted control word, in program order.
    task automatic model_apply(input logic [7:0] b, input logic [7:0] c, output int n);
        if (c[7]) m_mar[15:8] = b;
        if (c[6]) m_mar[7:0] = b;
        if (c[5]) m_mdr = b;
        n = 0;
        if (c[1]) begin
            push(m_sp, 1'b1, m_mar[15:8]); m_sp = m_sp - 16'd1;
            push(m_sp, 1'b1, m_mar[7:0]);  m_sp = m_sp - 16'd1;
            n = 2;
        end else if (c[0]) begin
            m_sp = m_sp + 16'd1; push(m_sp, 1'b0, 8'h00); m_mar[7:0]  = m_rd(m_sp);
            m_sp = m_sp + 16'd1; push(m_sp, 1'b0, 8'h00); m_mar[15:8] = m_rd(m_sp);
            n = 2;
        end else if (c[4]) begin
            push(m_mar, 1'b1, m_mdr); n = 1;
        end else if (c[3]) begin
            push(m_mar + 16'd1, 1'b0, 8'h00); m_mdr = m_rd(m_mar + 16'd1); n = 1;
        end else if (c[2]) begin
            push(m_mar, 1'b0, 8'h00); m_mdr = m_rd(m_mar); n = 1;
        end
        if (n > 0 && ack_delay >= TMO) m_err = 1'b1;
    endtask

    task automatic measure(input int n, input bit inject, output int cnt);
        int per, exp_cnt;
        per = 1 + ((ack_delay + 1 < TMO) ? ack_delay + 1 : TMO);
        exp_cnt = (n == 0) ? 0 : n * per + 1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            if (inject && cnt == 2) begin strobe = 1'b1; bus = 8'h77; ctrl = 8'hE0; end
            if (inject && cnt == 3) strobe = 1'b0;
            cnt++;
            @(posedge clk); #1;
        end
        strobe = 1'b0;
        chk("busy_cycles", cnt, exp_cnt);
        chk("accesses_drained", exp_q.size(), 0);
    endtask

    task automatic start(input logic [7:0] b, input logic [7:0] c, output int n);
        @(negedge clk);
        bus = b; ctrl = c; strobe = 1'b1;
        model_apply(b, c, n);
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic issue(input logic [7:0] b, input logic [7:0] c, input bit inject, output int cnt);
        int n;
        start(b, c, n);
        measure(n, inject, cnt);
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [7:0] d);
        sram_mem[a] = d; ref_mem[a] = d;
    endtask

    function automatic acc_t last(input int k);
        return acc_log[acc_log.size() - k];
    endfunction

    // SRAM responder: acks after ack_delay request cycles, throws stray acks while idle.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        sif.sram_ack = 1'b0;
        sif.sram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sif.sram_ack = 1'b0; wcnt = 0;
            end else if (sif.sram_req) begin
                if (wcnt == ack_delay) begin
                    sif.sram_ack = 1'b1;
                    if (sif.sram_we) sram_mem[sif.sram_addr] = sif.sram_wdata;
                    else sif.sram_rdata = sram_mem[sif.sram_addr];
                end else begin
                    sif.sram_ack = 1'b0;
                end
                wcnt++;
            end else begin
                wcnt = 0;
                sif.sram_ack = ($urandom_range(0, 3) == 0);
                sif.sram_rdata = 8'($urandom);
            end
        end
    end

    initial begin : compare
        acc_t held, e;
        bit   prev_req;
        prev_req = 1'b0;
        held.addr = '0; held.we = 1'b0; held.wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (sif.sram_req && !prev_req) begin
                    held.addr = sif.sram_addr; held.we = sif.sram_we; held.wdata = sif.sram_wdata;
                    acc_log.push_back(held);
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL spurious_req: addr %h issued, none expected", held.addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("acc_addr", 32'(held.addr), 32'(e.addr));
                        chk("acc_we", 32'(held.we), 32'(e.we));
                        if (e.we) chk("acc_wdata", 32'(held.wdata), 32'(e.wdata));
                    end
                end else if (sif.sram_req) begin
                    chk("req_hold", {sif.sram_addr, 7'd0, sif.sram_we, sif.sram_wdata},
                        {held.addr, 7'd0, held.we, held.wdata});
                end
                if (busy !== 1'b1) chk("mem_out", 32'(mem_out), 32'(m_mdr));
                chk("err", 32'(err), 32'(m_err));
                prev_req = sif.sram_req;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int cnt, n;
        logic [7:0] save_h, save_l, c;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'($urandom);
            ref_mem[i] = sram_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(sif.sram_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_mem_out", 32'(mem_out), 32'h00);
        chk("reset_addr", 32'(sif.sram_addr), 32'h0000);
        chk("reset_we_wdata", {sif.sram_we, sif.sram_wdata}, 32'h0);

        set_mem(16'h1234, 8'hA5);
        issue(8'h12, C_LOADH, 1'b0, cnt);
        chk("no_op_busy", cnt, 0);
        issue(8'h34, C_LOADL | C_ENL, 1'b0, cnt);
        chk("rd_busy3", cnt, 3);
        chk("rd_addr", 32'(last(1).addr), 32'h1234);
        chk("rd_data", 32'(mem_out), 32'hA5);

        issue(8'hFF, C_LOADH | C_LOADL, 1'b0, cnt);
        issue(8'h00, C_ENH, 1'b0, cnt);
        chk("enh_wrap", 32'(last(1).addr), 32'h0000);

        issue(8'h01, C_LOADH, 1'b0, cnt);
        issue(8'h00, C_LOADL, 1'b0, cnt);
        issue(8'h5C, C_MDR | C_WR, 1'b0, cnt);
        chk("wr_access", {last(1).addr, 7'd0, last(1).we, last(1).wdata}, 32'h0100_015C);

        issue(8'hBE, C_LOADH, 1'b0, cnt);
        issue(8'hEF, C_LOADL, 1'b0, cnt);
        issue(8'h00, C_CALL, 1'b0, cnt);
        chk("call_busy5", cnt, 5);
        chk("call_push_h", {last(2).addr, 7'd0, last(2).we, last(2).wdata}, 32'hFFFF_01BE);
        chk("call_push_l", {last(1).addr, 7'd0, last(1).we, last(1).wdata}, 32'hFFFE_01EF);
        issue(8'h00, C_LOADH | C_LOADL, 1'b0, cnt);
        issue(8'h00, C_RET, 1'b0, cnt);
        chk("ret_pop_l", {last(2).addr, 8'(last(2).we)}, 24'hFFFE00);
        chk("ret_pop_h", {last(1).addr, 8'(last(1).we)}, 24'hFFFF00);
        issue(8'h00, C_ENL, 1'b0, cnt);
        chk("ret_mar", 32'(last(1).addr), 32'hBEEF);

        ack_delay = 5;
        issue(8'h00, C_ENL, 1'b1, cnt);
        chk("slow_busy", cnt, 8);
        ack_delay = 0;
        issue(8'h00, C_ENL, 1'b0, cnt);
        chk("ignored_strobe", 32'(last(1).addr), 32'hBEEF);

        save_h = ref_mem[16'hFFFF];
        save_l = ref_mem[16'hFFFE];
        ack_delay = 5;
        start(8'h00, C_CALL, n);
        repeat (2) @(posedge clk);
        chk("req_before_reset", 32'(sif.sram_req), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("reset_req_drop", 32'(sif.sram_req), 32'd0);
        chk("reset_busy_drop", 32'(busy), 32'd0);
        exp_q.delete();
        ref_mem[16'hFFFF] = save_h;
        ref_mem[16'hFFFE] = save_l;
        m_mar = 16'h0000; m_mdr = 8'h00; m_sp = 16'hFFFF; m_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        issue(8'h00, C_CALL, 1'b0, cnt);
        chk("sp_after_reset", {last(2).addr, last(1).addr}, 32'hFFFF_FFFE);

`ifdef MEM_TIMEOUT_EN
        ack_delay = 100;
        issue(8'h00, C_ENL, 1'b0, cnt);
        chk("tmo_busy", cnt, 18);
        chk("tmo_data", 32'(mem_out), 32'hFF);
        chk("tmo_err", 32'(err), 32'd1);
        ack_delay = 0;
`endif

        for (int i = 0; i < 200; i++) begin
            ack_delay = $urandom_range(0, 3);
            c = 8'($urandom);
            if ($urandom_range(0, 4) == 0) c = c & 8'hE0;
            issue(8'($urandom), c, 1'b0, cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory-side stage downstream of the SAP-2 core. It consumes the 8-bit BUS and the 8-bit CTRL_MEMORY word {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret}, and produces the byte the core reads as SRAM_OUT.
- Holds the 16-bit MAR, the MDR and the 16-bit stack pointer.
- Runs multi-cycle req/ack accesses to an external byte-wide SRAM.
- Asserts busy so the core's clock can be held while an access is in progress.

Parameters:
- SP_RESET, 16'hFFFF, stack pointer value after reset.
- TIMEOUT, 16, max cycles to wait for sram_ack; only used with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  free-running clock (not gated by hlt).
- rst  in  1  asynchronous, active-low reset.
- strobe  in  1  one-cycle pulse: ctrl/bus hold a valid core control word.
- bus  in  8  core data bus.
- ctrl  in  8  {mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl, call, ret}, MSB first.
- mem_out  out  8  MDR contents; drives the core's SRAM_OUT.
- busy  out  1  a memory operation is in progress; core must stall.
- sram_req  out  1  access request.
- sram_we  out  1  1 = write, 0 = read.
- sram_addr  out  16  access address.
- sram_wdata  out  8  write data.
- sram_rdata  in  8  read data; valid in the ack cycle.
- sram_ack  in  1  access complete.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst low):
  - MAR=0, MDR=0, SP=SP_RESET, state=IDLE.
  - busy=0, sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0, err=0.
  - Reset mid-access aborts the access immediately; req drops asynchronously.
- Acceptance: ctrl is sampled only on strobe=1 in state IDLE. strobe in any other state is ignored.
- Register loads, applied in the accept cycle:
  - mar_loadh: MAR[15:8]<=bus.
  - mar_loadl: MAR[7:0]<=bus.
  - mdr_load: MDR<=bus.
  - Any combination is allowed; loadh and loadl together set both bytes to bus.
- Memory op: at most one per strobe, priority call > ret > ram_load > ram_enh > ram_enl. Any op uses MAR/MDR values including same-strobe loads (bus forwarded).
- Op definitions:
  - ram_enl: MDR<=mem[MAR].
  - ram_enh: MDR<=mem[MAR+1]; MAR+1 wraps 16'hFFFF->16'h0000.
  - ram_load: mem[MAR]<=MDR.
  - call: mem[SP]<=MAR[15:8], SP--, then mem[SP]<=MAR[7:0], SP--.
  - ret: SP++, MAR[7:0]<=mem[SP], then SP++, MAR[15:8]<=mem[SP].
  - SP arithmetic is modulo 2^16.
- FSM states: IDLE, RD, WR, PUSH_H, PUSH_L, POP_L, POP_H.
  - IDLE->RD for ram_enl/ram_enh; IDLE->WR for ram_load.
  - call: IDLE->PUSH_H->PUSH_L->IDLE.
  - ret: IDLE->POP_L->POP_H->IDLE.
  - Each non-IDLE state performs exactly one SRAM access and advances in the cycle after ack.
- busy: registered. It is 1 from the cycle after accept until the cycle after the final ack. A strobe with no memory op never raises busy.
- SRAM handshake:
  - req, we, addr and wdata are registered and stable while req=1.
  - req rises the cycle after the state is entered and falls the cycle after ack is sampled.
  - Minimum one idle cycle between accesses.
  - ack while req=0 is ignored.
  - Read data is captured in the ack cycle.
- Latency with ack on the first req cycle: RD/WR = 3 cycles accept->busy low; call/ret = 5 cycles.
- mem_out updates the cycle after the read ack.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a cycle counter runs while req=1. If ack is not seen within TIMEOUT cycles:
  - the access is aborted and err is set (sticky until reset);
  - the read value is replaced by 8'hFF;
  - the FSM continues as if acked, so call/ret still complete and SP still updates.
- Undefined: no counter; the bridge waits for ack indefinitely and err is tied to 0.

Test Plan:
- Reset -> MAR=0, MDR=0, SP=16'hFFFF, busy=0, req=0, mem_out=0.
- strobe bus=8'h12 mar_loadh; strobe bus=8'h34 mar_loadl+ram_enl, SRAM returns 8'hA5 at 16'h1234 -> one read at addr 16'h1234, mem_out=8'hA5, busy high 3 cycles.
- MAR=16'hFFFF, ram_enh -> sram_addr=16'h0000 (wrap).
- strobe bus=8'h5C mdr_load+ram_load with MAR=16'h0100 -> single write, we=1, addr 16'h0100, wdata 8'h5C.
- MAR=16'hBEEF, call then ret with MAR cleared to 0 between them:
  - call writes 8'hBE@16'hFFFF then 8'hEF@16'hFFFE; SP=16'hFFFD.
  - ret reads 16'hFFFE then 16'hFFFF; MAR=16'hBEEF, SP=16'hFFFF.
- Ack delayed 5 cycles with a strobe mid-access; async reset mid-call:
  - req is held stable throughout the delay; the mid-access strobe is ignored.
  - the reset drops req and busy at once and restores SP=16'hFFFF.
  - with MEM_TIMEOUT_EN and ack never arriving: err=1 after 16 cycles, mem_out=8'hFF.
